// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types for the instruction fetch front end
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HALT    = 2'd2
  } ifetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ifetch_entry_t;

  localparam int ENTRY_W = $bits(ifetch_entry_t);

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction queue with flush, no fall-through
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty && !flush;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push  = push && !flush && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - fetch PC, single-outstanding icache request and redirect FSM
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic [31:0] ic_rdata,
  input  logic        ic_rvalid,
  input  logic        ic_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int NW = CW + 1;
  localparam logic [NW-1:0] DEPTH_C = NW'(QUEUE_DEPTH);

  ifetch_state_e state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;

  logic          resp;
  logic          push;
  logic          pop;
  logic          space;
  logic [CW-1:0] count;
  logic [NW-1:0] cnt_next;
  logic          full;
  logic          empty;
  ifetch_entry_t push_entry;
  ifetch_entry_t head;

  assign resp = req_q && (ic_fault || ic_rvalid);
  assign pop  = !empty && if_ready;
  assign push = resp && (state_q == ST_FETCH) && !redirect_valid;

  always_comb begin
    push_entry.pc    = pc_q;
    push_entry.instr = ic_fault ? 32'h0 : ic_rdata;
    push_entry.fault = ic_fault;
  end

  assign cnt_next = {1'b0, count} + NW'(push) - NW'(pop);
  assign space    = redirect_valid || (full ? pop : (cnt_next < DEPTH_C));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (push && !ic_fault) pc_d = pc_q + 32'd4;
    if (redirect_valid)    pc_d = word_align(redirect_pc);

    case (state_q)
      ST_FETCH:   if (resp && ic_fault) state_d = ST_HALT;
      ST_DISCARD: if (resp) state_d = ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_FETCH;
    endcase
    // An in-flight request cannot be aborted; its response is dropped later.
    if (redirect_valid) state_d = (req_q && !resp) ? ST_DISCARD : ST_FETCH;

    req_d  = 1'b0;
    addr_d = addr_q;
    if (req_q && !resp) begin
      req_d = 1'b1;
    end else if ((state_d == ST_FETCH) && space) begin
      req_d  = 1'b1;
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= word_align(RESET_PC);
      req_q   <= 1'b0;
      addr_q  <= word_align(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign ic_req   = req_q;
  assign ic_addr  = addr_q;
  assign if_valid = !empty;
  assign if_pc    = empty ? 32'h0 : head.pc;
  assign if_instr = empty ? 32'h0 : head.instr;
  assign if_fault = !empty && head.fault;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed bench for ifetch_unit with a small icache model
module tb_ifetch_unit;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk;
  logic        rst_n;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_rvalid;
  logic        ic_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  logic        auto_en;
  logic        auto_rv;
  logic        man_rv;
  logic        fault_en;
  logic [31:0] fault_addr;

  logic        w_ic_req;
  logic [31:0] w_ic_addr;
  logic [31:0] w_ic_rdata;
  logic        w_ic_rvalid;
  logic        w_if_valid;
  logic [31:0] w_if_instr;
  logic [31:0] w_if_pc;
  logic        w_if_fault;

  int total;
  int bad;

  ifetch_unit #(.RESET_PC(32'h0000_0100), .QUEUE_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_fault(ic_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_fault(if_fault)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QUEUE_DEPTH(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .ic_req(w_ic_req), .ic_addr(w_ic_addr),
    .ic_rdata(w_ic_rdata), .ic_rvalid(w_ic_rvalid), .ic_fault(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_valid(w_if_valid), .if_ready(1'b1), .if_instr(w_if_instr),
    .if_pc(w_if_pc), .if_fault(w_if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache model: a hit returns one cycle after the request is first seen.
  assign ic_rdata   = ic_addr ^ KEY;
  assign ic_rvalid  = auto_en ? auto_rv : man_rv;
  assign ic_fault   = fault_en && ic_req && (ic_addr == fault_addr);
  assign w_ic_rdata = w_ic_addr ^ KEY;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) auto_rv <= 1'b0;
    else        auto_rv <= auto_en && ic_req && !auto_rv;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_ic_rvalid <= 1'b0;
    else        w_ic_rvalid <= w_ic_req && !w_ic_rvalid;
  end

  task automatic do_reset(input logic ae, input logic rdy);
    rst_n          = 1'b0;
    auto_en        = ae;
    man_rv         = 1'b0;
    fault_en       = 1'b0;
    fault_addr     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = rdy;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    man_rv         = 1'b0;
    if_ready       = 1'b0;
    @(negedge clk);
    total++; if (ic_req !== 1'b0) begin bad++; $display("FAIL reset_ic_req: got %b want 0", ic_req); end
    total++; if (ic_addr !== 32'h100) begin bad++; $display("FAIL reset_ic_addr: got %h want 00000100", ic_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL reset_if_instr: got %h want 0", if_instr); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    total++; if (if_fault !== 1'b0) begin bad++; $display("FAIL reset_if_fault: got %b want 0", if_fault); end
    total++; if (w_ic_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL reset_wrap_addr: got %h want fffffffc", w_ic_addr); end
  endtask

  task automatic test_sequential;
    int nresp, npop, last, c;
    logic [31:0] exp_pc;
    do_reset(1'b1, 1'b1);
    @(negedge clk);
    total++; if ({ic_req, ic_addr} !== {1'b1, 32'h100}) begin bad++; $display("FAIL first_req: got req=%b addr=%h want 1/00000100", ic_req, ic_addr); end
    nresp = 0; npop = 0; last = 0; c = 0;
    while (npop < 3 && c < 30) begin
      if (ic_req && ic_rvalid) begin
        exp_pc = 32'h100 + 32'(4 * nresp);
        total++; if (ic_addr !== exp_pc) begin bad++; $display("FAIL seq_addr%0d: got %h want %h", nresp, ic_addr, exp_pc); end
        nresp++;
      end
      if (if_valid) begin
        exp_pc = 32'h100 + 32'(4 * npop);
        total++; if (if_pc !== exp_pc) begin bad++; $display("FAIL seq_pc%0d: got %h want %h", npop, if_pc, exp_pc); end
        total++; if (if_instr !== (exp_pc ^ KEY)) begin bad++; $display("FAIL seq_instr%0d: got %h want %h", npop, if_instr, exp_pc ^ KEY); end
        if (npop == 0) begin
          total++; if (c !== 2) begin bad++; $display("FAIL seq_latency: got %0d want 2", c); end
        end else begin
          total++; if (c - last !== 2) begin bad++; $display("FAIL seq_gap%0d: got %0d want 2", npop, c - last); end
        end
        last = c;
        npop++;
      end
      c++;
      @(negedge clk);
    end
    total++; if (npop !== 3) begin bad++; $display("FAIL seq_timeout: got %0d pops want 3", npop); end
  endtask

  task automatic test_backpressure;
    int pushes, leak;
    do_reset(1'b1, 1'b0);
    pushes = 0; leak = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (pushes >= 4 && ic_req) leak++;
      if (ic_req && ic_rvalid) pushes++;
    end
    total++; if (pushes !== 4) begin bad++; $display("FAIL bp_pushes: got %0d want 4", pushes); end
    total++; if (leak !== 0) begin bad++; $display("FAIL bp_req_leak: got %0d cycles want 0", leak); end
    total++; if ({if_valid, if_pc} !== {1'b1, 32'h100}) begin bad++; $display("FAIL bp_head: got v=%b pc=%h want 1/00000100", if_valid, if_pc); end
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    total++; if ({ic_req, ic_addr} !== {1'b1, 32'h110}) begin bad++; $display("FAIL bp_resume: got req=%b addr=%h want 1/00000110", ic_req, ic_addr); end
    total++; if (if_pc !== 32'h104) begin bad++; $display("FAIL bp_next_head: got %h want 00000104", if_pc); end
  endtask

  task automatic test_miss_redirect;
    int held;
    do_reset(1'b0, 1'b1);
    redirect_pc = 32'h2000;
    held = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if ({ic_req, ic_addr} !== {1'b1, 32'h100}) held++;
      redirect_valid = (i == 2);
      man_rv = (i == 8);
    end
    total++; if (held !== 0) begin bad++; $display("FAIL miss_hold: got %0d bad cycles want 0", held); end
    @(negedge clk);
    man_rv = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL miss_dropped: got if_valid=%b want 0", if_valid); end
    total++; if ({ic_req, ic_addr} !== {1'b1, 32'h2000}) begin bad++; $display("FAIL miss_next_req: got req=%b addr=%h want 1/00002000", ic_req, ic_addr); end
    man_rv = 1'b1;
    @(negedge clk);
    man_rv = 1'b0;
    total++; if ({if_valid, if_pc} !== {1'b1, 32'h2000}) begin bad++; $display("FAIL miss_first_pc: got v=%b pc=%h want 1/00002000", if_valid, if_pc); end
    total++; if (if_instr !== (32'h2000 ^ KEY)) begin bad++; $display("FAIL miss_first_instr: got %h want %h", if_instr, 32'h2000 ^ KEY); end
    total++; if (ic_addr !== 32'h2004) begin bad++; $display("FAIL miss_pc_advance: got %h want 00002004", ic_addr); end
  endtask

  task automatic test_fault;
    int leak;
    do_reset(1'b0, 1'b0);
    fault_addr = 32'h300;
    fault_en   = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h301;
    man_rv         = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    man_rv         = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL redir_rvalid_nopush: got if_valid=%b want 0", if_valid); end
    total++; if ({ic_req, ic_addr} !== {1'b1, 32'h300}) begin bad++; $display("FAIL fault_req: got req=%b addr=%h want 1/00000300", ic_req, ic_addr); end
    @(negedge clk);
    total++; if ({if_valid, if_fault} !== 2'b11) begin bad++; $display("FAIL fault_entry: got v=%b f=%b want 1/1", if_valid, if_fault); end
    total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL fault_instr: got %h want 0", if_instr); end
    total++; if (if_pc !== 32'h300) begin bad++; $display("FAIL fault_pc: got %h want 00000300", if_pc); end
    if_ready = 1'b1;
    leak = 0;
    for (int i = 0; i < 4; i++) begin
      if (ic_req !== 1'b0) leak++;
      @(negedge clk);
    end
    if_ready = 1'b0;
    total++; if (leak !== 0) begin bad++; $display("FAIL fault_halt: got %0d req cycles want 0", leak); end
    fault_en       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    @(negedge clk);
    redirect_valid = 1'b0;
    total++; if ({ic_req, ic_addr} !== {1'b1, 32'h400}) begin bad++; $display("FAIL fault_resume: got req=%b addr=%h want 1/00000400", ic_req, ic_addr); end
  endtask

  task automatic test_redirect_pop;
    int c;
    do_reset(1'b1, 1'b0);
    c = 0;
    @(negedge clk);
    while (!(ic_req && ic_rvalid && if_valid) && c < 20) begin
      @(negedge clk);
      c++;
    end
    total++; if (c >= 20) begin bad++; $display("FAIL rp_setup_timeout: got %0d cycles want <20", c); end
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h5000;
    @(negedge clk);
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rp_flush: got if_valid=%b want 0", if_valid); end
    total++; if ({ic_req, ic_addr} !== {1'b1, 32'h5000}) begin bad++; $display("FAIL rp_next_req: got req=%b addr=%h want 1/00005000", ic_req, ic_addr); end
    repeat (2) @(negedge clk);
    total++; if ({if_valid, if_pc} !== {1'b1, 32'h5000}) begin bad++; $display("FAIL rp_first_pc: got v=%b pc=%h want 1/00005000", if_valid, if_pc); end
  endtask

  task automatic test_wrap;
    int nr, np, c;
    logic [31:0] ra [2];
    logic [31:0] pa [2];
    logic [31:0] ia [2];
    do_reset(1'b1, 1'b1);
    nr = 0; np = 0; c = 0;
    ra[0] = 32'h1; ra[1] = 32'h1; pa[0] = 32'h1; pa[1] = 32'h1; ia[0] = 32'h1; ia[1] = 32'h1;
    while (np < 2 && c < 30) begin
      @(negedge clk);
      if (w_ic_req && w_ic_rvalid && nr < 2) begin ra[nr] = w_ic_addr; nr++; end
      if (w_if_valid) begin
        total++; if (w_if_fault !== 1'b0) begin bad++; $display("FAIL wrap_fault%0d: got %b want 0", np, w_if_fault); end
        pa[np] = w_if_pc; ia[np] = w_if_instr; np++;
      end
      c++;
    end
    total++; if (ra[0] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req0: got %h want fffffffc", ra[0]); end
    total++; if (ra[1] !== 32'h0) begin bad++; $display("FAIL wrap_req1: got %h want 00000000", ra[1]); end
    total++; if (pa[0] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc0: got %h want fffffffc", pa[0]); end
    total++; if (pa[1] !== 32'h0) begin bad++; $display("FAIL wrap_pc1: got %h want 00000000", pa[1]); end
    total++; if (ia[1] !== KEY) begin bad++; $display("FAIL wrap_instr1: got %h want %h", ia[1], KEY); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    auto_en = 1'b0;
    man_rv = 1'b0;
    fault_en = 1'b0;
    fault_addr = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    if_ready = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_reset();
    test_miss_redirect();
    test_fault();
    test_redirect_pop();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch front end that sits directly upstream of the instruction cache. It generates the sequential fetch PC and drives one request at a time into the cache's fetch port. Returned words go into a small instruction queue, which the decode stage drains through a valid/ready handshake. Branch redirects flush the queue and retarget the PC. Because a cache request cannot be aborted, a redirect that arrives mid-request lets that request complete, and the response is then discarded.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] ignored.
- QUEUE_DEPTH, 4, instruction queue entries; power of two, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock
- rst_n  in  1  async active-low reset
- ic_req  out  1  fetch request to icache, registered
- ic_addr  out  32  fetch address; always word-aligned
- ic_rdata  in  32  returned instruction word
- ic_rvalid  in  1  single-cycle hit/return strobe
- ic_fault  in  1  fetch fault; MPU no-execute or bus fault
- redirect_valid  in  1  single-cycle PC redirect from execute
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0
- if_valid  out  1  queue head valid
- if_ready  in  1  decode accepts head
- if_instr  out  32  head instruction; 0 when the head is a fault entry
- if_pc  out  32  head PC
- if_fault  out  1  head is a fault entry

## Operation
- States:
  - FETCH: normal fetching.
  - DISCARD: an outstanding response will be dropped.
  - HALT: fetching stopped after a fault.
- Response condition: ic_req && (ic_fault || ic_rvalid). ic_fault has priority over ic_rvalid.
- Request rules:
  - ic_addr = pc_q.
  - Once raised, ic_req and ic_addr stay stable until a response arrives.
  - At most one request is outstanding.
  - A new request is issued only in FETCH, and only when the queue count after this cycle's push and pop is < QUEUE_DEPTH.
  - On a response, ic_req stays high into the next cycle, with the next address, if this space condition still holds.
- FETCH, response with rvalid: push {pc_q, ic_rdata, 0}; pc_q += 4, wrapping 32'hFFFF_FFFC → 0.
- FETCH, response with fault: push {pc_q, 0, 1}; drop ic_req; go to HALT.
- Redirect, in any state:
  - Flush the queue; if_valid is 0 from the next cycle.
  - Load the target into pc_q.
  - Any push in the same cycle is suppressed.
  - A pop in the same cycle is ignored, because the queue is flushed.
- Redirect with a request outstanding and no response this cycle: go to DISCARD, holding the old ic_addr until the response.
- Redirect otherwise: go to FETCH.
- DISCARD:
  - The response is dropped whether it is rvalid or fault, and the state goes to FETCH.
  - A further redirect while in DISCARD only updates the pending target.
- HALT: ic_req is 0; only a redirect leaves HALT.

## Timing
- Reset values:
  - ic_req 0; ic_addr RESET_PC; if_valid 0; if_instr 0; if_pc 0; if_fault 0.
  - State FETCH, queue empty.
- First ic_req is asserted in the first clock edge after rst_n deasserts.
- Hit latency: ic_req asserted in cycle N → ic_rvalid in N+1 → if_valid in N+2. The queue has no bypass.
- Sustained hit throughput is 1 instruction every 2 cycles, limited by the cache IDLE→LOOKUP path.
- Refill latency is absorbed; ic_req is simply held.
- Pop occurs when if_valid && if_ready. A push and a pop in the same cycle are both legal.
- ic_fault is combinational from the cache and may arrive in the same cycle ic_req is first seen.
- Reset mid-request: all state is cleared immediately. The cache is reset by the same rst_n.

## Structure
- The shared package holds the state enum ifetch_state_e and the queue entry typedef ifetch_entry_t {pc[31:0], instr[31:0], fault}.
- Sub-module fetch_fifo is a synchronous FIFO with parameterised depth and width and a flush input. It has no fall-through. It exposes count, full, and empty.
- Top-level logic: the PC register, the request register, and the FSM.

## Test plan
- Reset with RESET_PC=32'h100, cache always hits → ic_addr sequence 100, 104, 108; decode sees if_pc 100/104/108 with the matching instrs; an if_valid pulse every 2 cycles.
- Hold if_ready=0 with QUEUE_DEPTH=4 → exactly 4 entries pushed; ic_req stays low until the first pop, then resumes at 0x110.
- Miss held 9 cycles; redirect_pc=32'h2000 on cycle 3 → ic_addr holds the old value until rvalid; the response is dropped; the next request is at 0x2000; the first if_pc is 0x2000.
- ic_fault on a fetch at 0x300 → queue entry with if_fault=1, if_instr=0, if_pc=0x300; ic_req stays 0; a later redirect to 0x400 resumes fetching.
- Redirect in the same cycle as ic_rvalid and a pop → no push; queue empty next cycle; next ic_addr equals redirect_pc.
- PC wrap: RESET_PC=32'hFFFF_FFFC → second request at 32'h0000_0000.
